// File: rtl/conv_k_mem_addr_gen.sv
// conv_k_mem_addr_gen: kernel weight read-address generator (clk, reset async high, start, stall in; addr[LANES*ADDR_W], addr_valid, k_last, grp_idx, busy, done out)
module conv_k_mem_addr_gen #(
  parameter int KSIZE  = 25,
  parameter int NKERN  = 6,
  parameter int LANES  = 2,
  parameter int REPEAT = 64,
  parameter int ADDR_W = 8,
  localparam int GROUPS = NKERN / LANES,
  localparam int EW = KSIZE > 1 ? $clog2(KSIZE) : 1,
  localparam int RW = REPEAT > 1 ? $clog2(REPEAT) : 1,
  localparam int GW = GROUPS > 1 ? $clog2(GROUPS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stall,
  output logic [LANES*ADDR_W-1:0]   addr,
  output logic                      addr_valid,
  output logic                      k_last,
  output logic [GW-1:0]             grp_idx,
  output logic                      busy,
  output logic                      done
);
  if (NKERN % LANES != 0 || NKERN * KSIZE > 2 ** ADDR_W) begin : g_bad_params
    $error("conv_k_mem_addr_gen: illegal parameter set");
  end
  localparam logic [EW-1:0] E_MAX = EW'(KSIZE - 1);
  localparam logic [RW-1:0] R_MAX = RW'(REPEAT - 1);
  localparam logic [GW-1:0] G_MAX = GW'(GROUPS - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [EW-1:0] e, e_n;
  logic [RW-1:0] r, r_n;
  logic [GW-1:0] g, g_n;
  logic e_last, r_last, g_last;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      e <= '0;
      r <= '0;
      g <= '0;
    end else begin
      state <= state_n;
      e <= e_n;
      r <= r_n;
      g <= g_n;
    end
  assign e_last = e == E_MAX;
  assign r_last = r == R_MAX;
  assign g_last = g == G_MAX;
  always_comb begin
    state_n = state;
    e_n = e;
    r_n = r;
    g_n = g;
    if (state == IDLE)
      state_n = start ? RUN : IDLE;
    else if (state == FIN)
      state_n = IDLE;
    else if (!stall) begin
      e_n = e_last ? '0 : e + 1'b1;
      r_n = e_last ? (r_last ? '0 : r + 1'b1) : r;
      g_n = e_last && r_last ? (g_last ? '0 : g + 1'b1) : g;
      state_n = e_last && r_last && g_last ? FIN : RUN;
    end
  end
  assign busy       = state == RUN;
  assign addr_valid = busy && !stall;
  assign k_last     = busy && e_last;
  assign done       = state == FIN;
  assign grp_idx    = g;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign addr[l*ADDR_W +: ADDR_W] = ADDR_W'(l * GROUPS * KSIZE) + ADDR_W'(g) * ADDR_W'(KSIZE) + ADDR_W'(e);
  end
endmodule
